// File: rtl/bird_io_bridge.sv
// Memory-mapped I/O bridge for the bird CPU bus: RAM passthrough plus keyboard FIFO,
// display register and countdown timer. The timer exists only when BIRD_IO_TIMER_EN is defined.
module bird_io_bridge #(
  parameter logic [11:0] IO_BASE    = 12'hF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          PRESCALE   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cpu_address,
  input  logic [15:0] cpu_data_out,
  input  logic        cpu_memwt,
  output logic [15:0] cpu_data_in,
  output logic [11:0] ram_address,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic [15:0] seg_value
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       io_hit, io_wr;
  logic [3:0] off;

  assign io_hit      = (cpu_address[11:4] == IO_BASE[11:4]);
  assign off         = cpu_address[3:0];
  assign io_wr       = cpu_memwt && io_hit;
  assign ram_address = cpu_address;
  assign ram_wdata   = cpu_data_out;
  assign ram_we      = cpu_memwt && !io_hit;

  // ---------------- keyboard FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;
  logic [7:0]    head;
  logic [4:0]    cnt5;
  logic [3:0]    cnt_disp;

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign kb_ready = !full;
  assign push     = kb_valid && !full;
  assign pop      = io_wr && (off == 4'd2) && !empty;
  assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign cnt5     = 5'(cnt_q);
  assign cnt_disp = (cnt5 > 5'd15) ? 4'hF : cnt5[3:0];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= kb_data;
  end

  // ---------------- display register ----------------
  logic [15:0] seg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    seg_q <= 16'h0000;
    else if (io_wr && off == 4'd3) seg_q <= cpu_data_out;
  end

  assign seg_value = seg_q;

  // ---------------- countdown timer ----------------
  logic [15:0] tmr_rd;
  logic        tmr_exp;

`ifdef BIRD_IO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [15:0]   tmr_q, tmr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          exp_q, exp_d;

  // A load in the same cycle as a decrement takes priority.
  always_comb begin
    tmr_d = tmr_q;
    pre_d = pre_q;
    exp_d = exp_q;
    if (io_wr && off == 4'd4) begin
      tmr_d = cpu_data_out;
      pre_d = '0;
      exp_d = 1'b0;
    end else if (tmr_q != 16'h0000) begin
      if (pre_q == PW'(PRESCALE - 1)) begin
        pre_d = '0;
        tmr_d = tmr_q - 16'h0001;
        if (tmr_q == 16'h0001) exp_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= 16'h0000;
      pre_q <= '0;
      exp_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      pre_q <= pre_d;
      exp_q <= exp_d;
    end
  end

  assign tmr_rd  = tmr_q;
  assign tmr_exp = exp_q;
`else
  assign tmr_rd  = 16'h0000;
  assign tmr_exp = 1'b0;
`endif

  // ---------------- read mux ----------------
  logic [15:0] io_rdata;

  always_comb begin
    io_rdata = 16'h0000;
    case (off)
      4'd0:    io_rdata = {8'h00, cnt_disp, 1'b0, tmr_exp, full, !empty};
      4'd1:    io_rdata = {8'h00, head};
      4'd3:    io_rdata = seg_q;
      4'd4:    io_rdata = tmr_rd;
      default: io_rdata = 16'h0000;
    endcase
  end

  assign cpu_data_in = io_hit ? io_rdata : ram_rdata;

endmodule

// File: tb/tb_bird_io_bridge.sv
// Randomized bench for bird_io_bridge against a queue/arithmetic reference model.
module tb_bird_io_bridge;
  localparam int          DEPTH = 8;
  localparam int          P     = 4;
  localparam logic [11:0] BASE  = 12'hF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] cpu_address = '0;
  logic [15:0] cpu_data_out = '0;
  logic        cpu_memwt = 1'b0;
  logic [15:0] cpu_data_in;
  logic [11:0] ram_address;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata = '0;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        kb_ready;
  logic [15:0] seg_value;

  bird_io_bridge #(.IO_BASE(BASE), .FIFO_DEPTH(DEPTH), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_memwt(cpu_memwt), .cpu_data_in(cpu_data_in), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .kb_valid(kb_valid),
    .kb_data(kb_data), .kb_ready(kb_ready), .seg_value(seg_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  byte unsigned q[$];
  logic [15:0]  m_seg = '0;
  int           m_load = 0;
  int           m_ticks = 0;
  bit           pushed;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_timer();
`ifdef BIRD_IO_TIMER_EN
    if (m_load == 0 || m_ticks >= m_load * P) return 16'h0000;
    return 16'(m_load - m_ticks / P);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic exp_expired();
`ifdef BIRD_IO_TIMER_EN
    return (m_load != 0) && (m_ticks >= m_load * P);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_rd(input logic [11:0] a, input logic [15:0] rd);
    int n;
    n = q.size();
    if (a[11:4] != BASE[11:4]) return rd;
    case (a[3:0])
      4'd0: return {8'h00, 4'((n > 15) ? 15 : n), 1'b0, exp_expired(), n == DEPTH, n != 0};
      4'd1: return (n == 0) ? 16'h0000 : {8'h00, q[0]};
      4'd3: return m_seg;
      4'd4: return exp_timer();
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic hit;
    hit = (cpu_address[11:4] == BASE[11:4]);
    chk({tag, ".rd"},   cpu_data_in, exp_rd(cpu_address, ram_rdata));
    chk({tag, ".we"},   ram_we, cpu_memwt && !hit);
    chk({tag, ".ra"},   ram_address, cpu_address);
    chk({tag, ".wd"},   ram_wdata, cpu_data_out);
    chk({tag, ".rdy"},  kb_ready, q.size() < DEPTH);
    chk({tag, ".seg"},  seg_value, m_seg);
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic step();
    logic hit, wr, do_pop;
    pushed = 1'b0;
    if (rst_n) begin
      hit    = (cpu_address[11:4] == BASE[11:4]);
      wr     = cpu_memwt && hit;
      do_pop = wr && cpu_address[3:0] == 4'd2 && q.size() > 0;
      pushed = kb_valid && q.size() < DEPTH;
      if (do_pop) void'(q.pop_front());
      if (pushed) q.push_back(kb_data);
      if (wr && cpu_address[3:0] == 4'd3) m_seg = cpu_data_out;
`ifdef BIRD_IO_TIMER_EN
      if (wr && cpu_address[3:0] == 4'd4) begin
        m_load  = int'(cpu_data_out);
        m_ticks = 0;
      end else if (m_ticks < 32'h3FFF_FFFF) m_ticks++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic io(input string tag, input logic [11:0] a, input logic [15:0] d, input logic we);
    cpu_address  = a;
    cpu_data_out = d;
    cpu_memwt    = we;
    ram_rdata    = 16'($urandom);
    #1;
    check_all(tag);
    step();
    cpu_memwt = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_seg   = '0;
    m_load  = 0;
    m_ticks = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    io("rst_f00", 12'hF00, 16'h0, 1'b0);
    io("rst_f01", 12'hF01, 16'h0, 1'b0);
    chk("rst_const_rdy", kb_ready, 1'b1);
    chk("rst_const_seg", seg_value, 16'h0000);

    // two pushes, status/head, pops incl. on empty
    kb_valid = 1'b1; kb_data = 8'h41; io("push", 12'h000, 16'h0, 1'b0);
    kb_data = 8'h42;                  io("push", 12'h001, 16'h0, 1'b0);
    kb_valid = 1'b0;
    cpu_address = 12'hF00; #1; chk("status_2", cpu_data_in, 16'h0021);
    io("st", 12'hF00, 16'h0, 1'b0);
    io("head", 12'hF01, 16'h0, 1'b0);
    io("pop", 12'hF02, 16'h0, 1'b1);
    io("head2", 12'hF01, 16'h0, 1'b0);
    repeat (3) io("pop_x", 12'hF02, 16'h0, 1'b1);
    cpu_address = 12'hF00; #1; chk("status_empty", cpu_data_in, 16'h0000);

    // fill to full, then hold 8'hFF while draining
    for (int i = 0; i < DEPTH; i++) begin
      kb_valid = 1'b1; kb_data = 8'(8'h10 + i);
      io("fill", 12'hF00, 16'h0, 1'b0);
    end
    kb_data = 8'hFF;
    cpu_address = 12'hF00; #1; chk("status_full", cpu_data_in, 16'h0083);
    for (int i = 0; i < DEPTH + 2; i++) begin
      io("drain_h", 12'hF01, 16'h0, 1'b0);
      if (pushed) kb_valid = 1'b0;
      io("drain_p", 12'hF02, 16'h0, 1'b1);
      if (pushed) kb_valid = 1'b0;
    end
    kb_valid = 1'b0;
    io("drained", 12'hF00, 16'h0, 1'b0);

    // RAM passthrough, display, reserved offset
    io("ram_wr", 12'h123, 16'hBEEF, 1'b1);
    io("disp_wr", 12'hF03, 16'hBEEF, 1'b1);
    chk("disp_const", seg_value, 16'hBEEF);
    io("rsv_wr", 12'hF07, 16'h1234, 1'b1);
    io("rsv_rd", 12'hF07, 16'h0, 1'b0);

    // timer countdown from 3; expiry after exactly 12 cycles
    io("tmr_ld", 12'hF04, 16'd3, 1'b1);
    for (int i = 0; i < 14; i++) begin
      io("tmr_rd", 12'hF04, 16'h0, 1'b0);
      io("tmr_st", 12'hF00, 16'h0, 1'b0);
    end
    io("tmr_ld5", 12'hF04, 16'd5, 1'b1);
    io("tmr_st5", 12'hF00, 16'h0, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [11:0] a;
      logic [15:0] d;
      logic        we;
      if ($urandom_range(0, 1) == 0) a = {BASE[11:4], 4'($urandom_range(0, 5))};
      else if ($urandom_range(0, 3) == 0) a = {BASE[11:4], 4'($urandom)};
      else a = 12'($urandom);
      we = ($urandom_range(0, 2) == 0);
      d  = (a[3:0] == 4'd4) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      io("rand", a, d, we);
      if (!kb_valid || pushed) begin
        kb_valid = ($urandom_range(0, 2) != 0);
        kb_data  = 8'($urandom);
      end
    end

    // asynchronous reset mid-operation: 3 entries, running timer
    kb_valid = 1'b0;
    while (q.size() > 0) io("flush", 12'hF02, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      kb_valid = 1'b1; kb_data = 8'(8'hA0 + i);
      io("pre_rst", 12'h010, 16'h0, 1'b0);
    end
    kb_valid = 1'b0;
    io("pre_tmr", 12'hF04, 16'd9, 1'b1);
    io("pre_seg", 12'hF03, 16'h5A5A, 1'b1);
    io("pre_chk", 12'hF00, 16'h0, 1'b0);
    cpu_address = 12'hF00;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("arst_st");
    chk("arst_st_const", cpu_data_in, 16'h0000);
    cpu_address = 12'hF04;
    #1 check_all("arst_tmr");
    chk("arst_tmr_const", cpu_data_in, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    io("post_rst", 12'hF01, 16'h0, 1'b0);
    io("post_rst2", 12'hF04, 16'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
